// File: rtl/rs_occupancy_ctrl_pkg.sv
// Shared scheduling constants for the reservation-station occupancy tracker.
package rs_occupancy_ctrl_pkg;
    localparam int NUM_RS           = 4;
    localparam int RS_BRANCH        = 0;
    localparam int RS_ALU1          = 1;
    localparam int RS_ALU2          = 2;
    localparam int RS_LDST          = 3;
    localparam int DEFAULT_RS_DEPTH = 8;
    localparam int DEFAULT_CNT_W    = 4;
endpackage

// File: rtl/rs_occupancy_ctrl_counter.sv
// One reservation station's occupancy: saturating up-2/down-1 counter with
// flush and a sticky overflow/underflow flag.
module rs_occupancy_counter #(
    parameter int RS_DEPTH = 8,
    parameter int CNT_W    = 4
) (
    input  logic             iCLOCK,
    input  logic             iRESET_SYNC,
    input  logic             iFLUSH,
    input  logic             iDISP_0,
    input  logic             iDISP_1,
    input  logic             iREL,
    output logic [CNT_W-1:0] oCOUNT,
    output logic             oERR
);
    // Two bits of headroom so count+2 stays positive even at RS_DEPTH=15.
    localparam int SUM_W = CNT_W + 2;
    typedef logic signed [SUM_W-1:0] sum_t;
    localparam sum_t DEPTH_S = sum_t'(RS_DEPTH);

    logic [CNT_W-1:0] r_count;
    logic             r_err;
    sum_t             w_sum;
    logic [CNT_W-1:0] w_next;
    logic             w_ovf;
    logic             w_unf;

    function automatic logic [CNT_W-1:0] sat_count(input sum_t v);
        if (v > DEPTH_S) begin
            return CNT_W'(RS_DEPTH);
        end else if (v < sum_t'(0)) begin
            return '0;
        end
        return CNT_W'(v);
    endfunction

    always_comb begin
        w_sum  = sum_t'(r_count) + sum_t'(iDISP_0) + sum_t'(iDISP_1) - sum_t'(iREL);
        w_ovf  = (w_sum > DEPTH_S);
        w_unf  = (w_sum < sum_t'(0));
        w_next = sat_count(w_sum);
    end

    // Stage boundary: registered count and sticky error.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (iFLUSH) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
            if (w_ovf || w_unf) begin
                r_err <= 1'b1;
            end
        end
    end

    assign oCOUNT = r_count;
    assign oERR   = r_err;
endmodule

// File: rtl/rs_occupancy_ctrl.sv
// Occupancy tracking for the four reservation stations; publishes counts,
// full flags and the conservative dispatch order-lock.
module rs_occupancy_ctrl
    import rs_occupancy_ctrl_pkg::*;
#(
    parameter int RS_DEPTH = DEFAULT_RS_DEPTH,
    parameter int CNT_W    = DEFAULT_CNT_W
) (
    input  logic              iCLOCK,
    input  logic              iRESET_SYNC,
    input  logic              iFLUSH,
    input  logic              iEXT_LOCK,
    input  logic [NUM_RS-1:0] iRS_DISP_0,
    input  logic [NUM_RS-1:0] iRS_DISP_1,
    input  logic [NUM_RS-1:0] iRS_REL,
    output logic [CNT_W-1:0]  oRS0_COUNT,
    output logic [CNT_W-1:0]  oRS1_COUNT,
    output logic [CNT_W-1:0]  oRS2_COUNT,
    output logic [CNT_W-1:0]  oRS3_COUNT,
    output logic [NUM_RS-1:0] oRS_FULL,
    output logic              oORDER_LOCK,
    output logic              oERR
);
    localparam logic [CNT_W-1:0] FULL_VAL = CNT_W'(RS_DEPTH);
    // Lock once fewer than two entries are free: both slots may hit one RS.
    localparam logic [CNT_W-1:0] LOCK_TH  = CNT_W'(RS_DEPTH - 2);

    logic [CNT_W-1:0]  w_count [NUM_RS];
    logic [NUM_RS-1:0] w_err;
    logic [NUM_RS-1:0] w_full;
    logic [NUM_RS-1:0] w_near;

    for (genvar g = 0; g < NUM_RS; g++) begin : g_rs
        rs_occupancy_counter #(
            .RS_DEPTH (RS_DEPTH),
            .CNT_W    (CNT_W)
        ) u_cnt (
            .iCLOCK      (iCLOCK),
            .iRESET_SYNC (iRESET_SYNC),
            .iFLUSH      (iFLUSH),
            .iDISP_0     (iRS_DISP_0[g]),
            .iDISP_1     (iRS_DISP_1[g]),
            .iREL        (iRS_REL[g]),
            .oCOUNT      (w_count[g]),
            .oERR        (w_err[g])
        );
    end

    always_comb begin
        w_full = '0;
        w_near = '0;
        for (int n = 0; n < NUM_RS; n++) begin
            w_full[n] = (w_count[n] == FULL_VAL);
            w_near[n] = (w_count[n] > LOCK_TH);
        end
    end

    assign oRS0_COUNT  = w_count[RS_BRANCH];
    assign oRS1_COUNT  = w_count[RS_ALU1];
    assign oRS2_COUNT  = w_count[RS_ALU2];
    assign oRS3_COUNT  = w_count[RS_LDST];
    assign oRS_FULL    = w_full;
    assign oORDER_LOCK = iEXT_LOCK | (|w_near);
    assign oERR        = |w_err;
endmodule

// File: tb/tb_rs_occupancy_ctrl.sv
// Scoreboard bench for rs_occupancy_ctrl: directed scenarios plus legal random traffic.
module tb_rs_occupancy_ctrl;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst, flush, ext;
    logic [3:0]    d0, d1, rel;
    logic [CW-1:0] c0, c1, c2, c3;
    logic [3:0]    full;
    logic          lock, err;

    always #5 clk = ~clk;

    rs_occupancy_ctrl #(.RS_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .iCLOCK      (clk),
        .iRESET_SYNC (rst),
        .iFLUSH      (flush),
        .iEXT_LOCK   (ext),
        .iRS_DISP_0  (d0),
        .iRS_DISP_1  (d1),
        .iRS_REL     (rel),
        .oRS0_COUNT  (c0),
        .oRS1_COUNT  (c1),
        .oRS2_COUNT  (c2),
        .oRS3_COUNT  (c3),
        .oRS_FULL    (full),
        .oORDER_LOCK (lock),
        .oERR        (err)
    );

    typedef struct packed {
        logic [3:0][CW-1:0] cnt;
        logic [3:0]         full;
        logic               lock;
        logic               err;
    } exp_t;

    exp_t q[$];
    int   m_cnt [4];
    bit   m_err;
    int   total = 0;
    int   bad   = 0;

    function automatic bit model_lock(input bit e);
        bit l = e;
        for (int n = 0; n < 4; n++) if (m_cnt[n] > DEPTH - 2) l = 1'b1;
        return l;
    endfunction

    // Apply one cycle of stimulus; update the reference model and queue the expected outputs.
    task automatic step(input logic [3:0] a0, a1, r, input logic f, rs, e);
        exp_t x;
        @(negedge clk);
        d0 = a0; d1 = a1; rel = r; flush = f; rst = rs; ext = e;
        @(posedge clk);
        if (rs) begin
            for (int n = 0; n < 4; n++) m_cnt[n] = 0;
            m_err = 1'b0;
        end else if (f) begin
            for (int n = 0; n < 4; n++) m_cnt[n] = 0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                int v;
                v = m_cnt[n] + int'(a0[n]) + int'(a1[n]) - int'(r[n]);
                if (v > DEPTH) begin v = DEPTH; m_err = 1'b1; end
                if (v < 0)     begin v = 0;     m_err = 1'b1; end
                m_cnt[n] = v;
            end
        end
        for (int n = 0; n < 4; n++) begin
            x.cnt[n]  = CW'(m_cnt[n]);
            x.full[n] = (m_cnt[n] == DEPTH);
        end
        x.lock = model_lock(e);
        x.err  = m_err;
        q.push_back(x);
    endtask

    task automatic fill(input int t0, t1, t2, t3);
        int t [4];
        logic [3:0] a0, a1;
        t[0] = t0; t[1] = t1; t[2] = t2; t[3] = t3;
        for (int k = 0; k < 10; k++) begin
            for (int n = 0; n < 4; n++) begin
                a0[n] = (m_cnt[n] < t[n]);
                a1[n] = (m_cnt[n] + 1 < t[n]);
            end
            if (a0 == 4'b0) break;
            step(a0, a1, 4'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every cycle with a queued expectation is a presented output.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (q.size() > 0) begin
            x = q.pop_front();
            chk("rs0_count", int'(c0), int'(x.cnt[0]));
            chk("rs1_count", int'(c1), int'(x.cnt[1]));
            chk("rs2_count", int'(c2), int'(x.cnt[2]));
            chk("rs3_count", int'(c3), int'(x.cnt[3]));
            chk("rs_full", int'(full), int'(x.full));
            chk("order_lock", int'(lock), int'(x.lock));
            chk("err", int'(err), int'(x.err));
        end
    end

    initial begin
        logic [3:0] a0, a1, r;
        logic f, e;
        rst = 1'b1; flush = 1'b0; ext = 1'b0; d0 = '0; d1 = '0; rel = '0;
        for (int n = 0; n < 4; n++) m_cnt[n] = 0;
        m_err = 1'b0;

        // Reset state, then RS1 fills two per cycle; lock rises at 7.
        step(4'b0, 4'b0, 4'b0, 1'b0, 1'b1, 1'b0);
        repeat (3) step(4'b0010, 4'b0010, 4'b0, 1'b0, 1'b0, 1'b0);
        step(4'b0010, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);

        // Dispatch and release on the same RS net to zero.
        step(4'b0, 4'b0, 4'b0, 1'b0, 1'b1, 1'b0);
        fill(0, 0, 5, 0);
        step(4'b0100, 4'b0, 4'b0100, 1'b0, 1'b0, 1'b0);
        step(4'b0, 4'b0, 4'b0100, 1'b0, 1'b0, 1'b0);

        // Flush wins over coincident dispatches.
        step(4'b0, 4'b0, 4'b0, 1'b0, 1'b1, 1'b0);
        fill(3, 7, 2, 8);
        step(4'b1111, 4'b1111, 4'b0, 1'b1, 1'b0, 1'b0);

        // Underflow sets sticky error that survives flush.
        step(4'b0, 4'b0, 4'b1000, 1'b0, 1'b0, 1'b0);
        step(4'b0, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0);
        step(4'b0001, 4'b0, 4'b0001, 1'b0, 1'b0, 1'b0);

        // Overflow at full saturates and flags.
        step(4'b0, 4'b0, 4'b0, 1'b0, 1'b1, 1'b0);
        fill(8, 0, 0, 0);
        step(4'b0001, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-stream with dispatch; external lock alone.
        step(4'b0, 4'b0, 4'b0, 1'b0, 1'b1, 1'b0);
        fill(4, 4, 4, 4);
        step(4'b1111, 4'b1111, 4'b0, 1'b0, 1'b1, 1'b0);
        step(4'b0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b1);

        // Legal random traffic: dispatch gated by lock, release only when occupied.
        for (int c = 0; c < 400; c++) begin
            int s0, s1;
            e  = ($urandom_range(0, 7) == 0);
            f  = ($urandom_range(0, 39) == 0);
            a0 = '0; a1 = '0; r = '0;
            if (!model_lock(e)) begin
                s0 = $urandom_range(0, 4);
                s1 = $urandom_range(0, 4);
                if (s0 < 4) a0[s0] = 1'b1;
                if (s1 < 4) a1[s1] = 1'b1;
            end
            for (int n = 0; n < 4; n++)
                r[n] = (m_cnt[n] > 0) && ($urandom_range(0, 2) == 0);
            step(a0, a1, r, f, 1'b0, e);
        end

        repeat (3) @(posedge clk);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
